// File: rtl/ex_mem_skid.sv
// EX/MEM boundary register with a two-entry skid buffer (main + skid).
// Latency: one cycle from accept to presentation on the outputs.
// Backpressure: in_ready is registered (!skid valid); absorbs one bundle after out_ready falls.
module ex_mem_skid #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              MemWrite_in,
    input  logic              MemRead_in,
    input  logic              Branch_in,
    input  logic              MemtoReg_in,
    input  logic              RegWrite_in,
    input  logic              Zero_in,
    input  logic [DATA_W-1:0] ALUResult_in,
    input  logic [DATA_W-1:0] ReadData2_in,
    input  logic [REG_W-1:0]  WriteReg_in,
    input  logic [DATA_W-1:0] BranchTarget_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              MemWrite_out,
    output logic              MemRead_out,
    output logic              Branch_out,
    output logic              MemtoReg_out,
    output logic              RegWrite_out,
    output logic              Zero_out,
    output logic [DATA_W-1:0] ALUResult_out,
    output logic [DATA_W-1:0] ReadData2_out,
    output logic [DATA_W-1:0] BranchTarget_out,
    output logic [REG_W-1:0]  WriteReg_out
);

    typedef struct packed {
        logic              memWrite;
        logic              memRead;
        logic              branch;
        logic              memtoReg;
        logic              regWrite;
        logic              zero;
        logic [DATA_W-1:0] aluResult;
        logic [DATA_W-1:0] readData2;
        logic [DATA_W-1:0] branchTarget;
        logic [REG_W-1:0]  writeReg;
    } bundle_t;

    bundle_t inBundle;
    bundle_t mainQ;
    bundle_t skidQ;
    logic    mV;
    logic    sV;
    logic    accept;
    logic    pop;

    assign inBundle = '{
        memWrite:     MemWrite_in,
        memRead:      MemRead_in,
        branch:       Branch_in,
        memtoReg:     MemtoReg_in,
        regWrite:     RegWrite_in,
        zero:         Zero_in,
        aluResult:    ALUResult_in,
        readData2:    ReadData2_in,
        branchTarget: BranchTarget_in,
        writeReg:     WriteReg_in
    };

    assign in_ready  = !sV;
    assign out_valid = mV;
    assign accept    = in_valid & in_ready & !Flush;
    assign pop       = mV & out_ready;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            mV    <= 1'b0;
            sV    <= 1'b0;
            mainQ <= '0;
            skidQ <= '0;
        end else if (Flush) begin
            // Payload registers keep their contents; only the valid bits squash.
            mV <= 1'b0;
            sV <= 1'b0;
        end else if (!mV) begin
            if (accept) begin
                mainQ <= inBundle;
                mV    <= 1'b1;
            end
        end else if (pop) begin
            if (sV) begin
                mainQ <= skidQ;
                sV    <= 1'b0;
            end else if (accept) begin
                mainQ <= inBundle;
            end else begin
                mV <= 1'b0;
            end
        end else if (!sV && accept) begin
            skidQ <= inBundle;
            sV    <= 1'b1;
        end
    end

    // Side-effecting controls are gated so an empty slot is a true bubble.
    assign MemWrite_out     = mainQ.memWrite & mV;
    assign MemRead_out      = mainQ.memRead & mV;
    assign Branch_out       = mainQ.branch & mV;
    assign RegWrite_out     = mainQ.regWrite & mV;
    assign MemtoReg_out     = mainQ.memtoReg;
    assign Zero_out         = mainQ.zero;
    assign ALUResult_out    = mainQ.aluResult;
    assign ReadData2_out    = mainQ.readData2;
    assign BranchTarget_out = mainQ.branchTarget;
    assign WriteReg_out     = mainQ.writeReg;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Bench for ex_mem_skid: directed scenarios plus random stress against a
// two-deep queue reference model with a decoupled output monitor.
module tb_ex_mem_skid;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam int VW     = 6 + 3 * DATA_W + REG_W;

    logic              Clk;
    logic              Rst_n;
    logic              Flush;
    logic              in_valid;
    logic              in_ready;
    logic              out_valid;
    logic              out_ready;
    logic              MemWrite_in, MemRead_in, Branch_in, MemtoReg_in, RegWrite_in, Zero_in;
    logic [DATA_W-1:0] ALUResult_in, ReadData2_in, BranchTarget_in;
    logic [REG_W-1:0]  WriteReg_in;
    logic              MemWrite_out, MemRead_out, Branch_out, MemtoReg_out, RegWrite_out, Zero_out;
    logic [DATA_W-1:0] ALUResult_out, ReadData2_out, BranchTarget_out;
    logic [REG_W-1:0]  WriteReg_out;

    logic [VW-1:0] inVec;
    logic [VW-1:0] outVec;
    logic [VW-1:0] lastVec;
    logic [VW-1:0] refQ[$];
    logic          expInReady;
    int            total;
    int            bad;
    int            accCount;
    int            popCount;

    assign {MemWrite_in, MemRead_in, Branch_in, MemtoReg_in, RegWrite_in, Zero_in,
            ALUResult_in, ReadData2_in, BranchTarget_in, WriteReg_in} = inVec;
    assign outVec = {MemWrite_out, MemRead_out, Branch_out, MemtoReg_out, RegWrite_out, Zero_out,
                     ALUResult_out, ReadData2_out, BranchTarget_out, WriteReg_out};

    ex_mem_skid #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in), .Branch_in(Branch_in),
        .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in), .Zero_in(Zero_in),
        .ALUResult_in(ALUResult_in), .ReadData2_in(ReadData2_in),
        .WriteReg_in(WriteReg_in), .BranchTarget_in(BranchTarget_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .MemWrite_out(MemWrite_out), .MemRead_out(MemRead_out), .Branch_out(Branch_out),
        .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out), .Zero_out(Zero_out),
        .ALUResult_out(ALUResult_out), .ReadData2_out(ReadData2_out),
        .BranchTarget_out(BranchTarget_out), .WriteReg_out(WriteReg_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] mk(input logic [DATA_W-1:0] alu, input logic [REG_W-1:0] wr,
                                         input logic mw, input logic rw);
        logic [VW-1:0] v;
        v = {$urandom, $urandom, $urandom, $urandom};
        v[106]     = mw;
        v[102]     = rw;
        v[100:69]  = alu;
        v[4:0]     = wr;
        return v;
    endfunction

    // Monitor: compares DUT against the reference queue just before each edge.
    always @(negedge Clk) begin
        if (Rst_n) begin
            chk("out_valid", 128'(out_valid), 128'(refQ.size() > 0));
            chk("in_ready", 128'(in_ready), 128'(refQ.size() < 2));
            expInReady = (refQ.size() < 2);
            if (refQ.size() > 0) begin
                chk("payload", 128'(outVec), 128'(refQ[0]));
                lastVec = refQ[0];
                if (out_ready) begin
                    void'(refQ.pop_front());
                    popCount++;
                end
            end else begin
                chk("bubble_ctl", 128'({MemWrite_out, MemRead_out, Branch_out, RegWrite_out}), 128'(0));
                chk("bubble_hold", 128'({ALUResult_out, WriteReg_out}),
                    128'({lastVec[100:69], lastVec[4:0]}));
            end
        end
    end

    // Drive one cycle of stimulus and record what the edge is required to accept.
    task automatic step(input logic iv, input logic orr, input logic fl, input logic [VW-1:0] v);
        @(posedge Clk);
        #1;
        in_valid  = iv;
        out_ready = orr;
        Flush     = fl;
        inVec     = v;
        @(negedge Clk);
        #1;
        if (fl) begin
            refQ.delete();
        end else if (iv && expInReady) begin
            refQ.push_back(v);
            accCount++;
        end
    endtask

    initial begin
        total = 0; bad = 0; accCount = 0; popCount = 0;
        expInReady = 1'b1;
        lastVec = '0;
        Rst_n = 1'b0; Flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; inVec = '0;
        #3;
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_in_ready", 128'(in_ready), 128'(1));
        chk("reset_outputs", 128'(outVec), 128'(0));
        #9 Rst_n = 1'b1;

        // Streaming
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 1'b0, mk(32'(i * 16), 5'(i), 1'b0, 1'b1));
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        chk("stream_pops", 128'(popCount), 128'(4));

        // Backpressure: A, B absorbed, C held off until skid drains
        step(1'b1, 1'b0, 1'b0, mk(32'hA, 5'd3, 1'b0, 1'b1));
        step(1'b1, 1'b0, 1'b0, mk(32'hB, 5'd7, 1'b0, 1'b1));
        step(1'b1, 1'b0, 1'b0, mk(32'hC, 5'd9, 1'b0, 1'b1));
        chk("bp_accepts", 128'(accCount), 128'(6));
        step(1'b1, 1'b1, 1'b0, mk(32'hC, 5'd9, 1'b0, 1'b1));
        step(1'b1, 1'b1, 1'b0, mk(32'hC, 5'd9, 1'b0, 1'b1));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, '0);
        chk("bp_pops", 128'(popCount), 128'(7));

        // Flush with both entries full and an incoming bundle
        step(1'b1, 1'b0, 1'b0, mk(32'h111, 5'd1, 1'b1, 1'b1));
        step(1'b1, 1'b0, 1'b0, mk(32'h222, 5'd2, 1'b1, 1'b1));
        step(1'b1, 1'b0, 1'b1, mk(32'h333, 5'd3, 1'b1, 1'b1));
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);

        // Bubble masking
        step(1'b1, 1'b1, 1'b0, mk(32'h55, 5'd5, 1'b1, 1'b1));
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);

        // Asynchronous reset mid-cycle with both entries full
        step(1'b1, 1'b0, 1'b0, mk(32'h777, 5'd17, 1'b1, 1'b1));
        step(1'b1, 1'b0, 1'b0, mk(32'h888, 5'd18, 1'b1, 1'b1));
        @(posedge Clk);
        #1 in_valid = 1'b0;
        #1 Rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_in_ready", 128'(in_ready), 128'(1));
        chk("midrst_outputs", 128'(outVec), 128'(0));
        refQ.delete();
        lastVec = '0;
        #1 Rst_n = 1'b1;

        // Random stress
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6),
                 1'($urandom_range(0, 49) == 0),
                 mk($urandom, 5'($urandom), 1'($urandom), 1'($urandom)));
        end
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
